reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
// - Parametrised multi-read-port register file for the next DaVinci datapath.
// - Configurable data width, depth and read-port count.
// - Registered reads with write-first bypass.
// - Sequenced bulk-clear FSM, so the core can wipe the file without pulsing RST.
// PARAMETERS
// - DW     32  data width in bits
// - DEPTH  32  number of registers (>=2)
// - AW     5   address width; must satisfy 2**AW >= DEPTH
// - NRD    2   number of read ports (1..4)
// PORTS
// - CLK      in   1       clock; all state changes on posedge
// - RST      in   1       reset, asynchronous, active-low
// - RD_EN    in   1       read strobe, shared by all read ports
// - RD_ADDR  in   NRD*AW  packed read addresses; port k = [k*AW +: AW]
// - RD_DATA  out  NRD*DW  packed read data; port k = [k*DW +: DW]
// - RD_VALID out  1       one-cycle pulse: RD_DATA updated this cycle
// - WR_EN    in   1       write strobe
// - WR_ADDR  in   AW      write address
// - WR_DATA  in   DW      write data
// - CLR_REQ  in   1       start a bulk clear (single-cycle pulse or level)
// - BUSY     out  1       high while the clear sequence runs
// BEHAVIOUR
// - Reset (RST=0, async):
//   - all registers, RD_DATA and the clear counter go to 0.
//   - RD_VALID=0, BUSY=0, FSM=IDLE.
//   - Reset asserted mid-clear aborts the sequence; the file ends fully zero.
// - FSM states are IDLE and CLEAR.
//   - IDLE->CLEAR on posedge with CLR_REQ=1. Counter loads 0 and BUSY rises next cycle.
//   - CLEAR: entry[counter] <= 0 and counter++ each cycle.
//   - CLEAR->IDLE on the cycle entry DEPTH-1 is zeroed. BUSY is high for exactly DEPTH cycles.
//   - CLR_REQ while in CLEAR is ignored (no restart).
// - Read, when RD_EN=1 and FSM=IDLE at posedge n:
//   - each port k samples entry[RD_ADDR_k]; RD_DATA_k is valid after edge n.
//   - RD_VALID=1 for that one cycle, latency 1.
//   - RD_EN=0: RD_DATA holds its last value and RD_VALID=0.
// - Write, when WR_EN=1 and FSM=IDLE: entry[WR_ADDR] <= WR_DATA at posedge.
// - Simultaneous read and write to the same address (write-first bypass):
//   - the read returns WR_DATA.
//   - all ports reading that address see the bypassed value.
// - Reads and writes both proceed in the same cycle. Unlike legacy, no mutual exclusion.
// - Out-of-range address (>= DEPTH):
//   - the write is dropped.
//   - the read returns 0 and RD_VALID still pulses.
// - CLR_REQ, WR_EN and RD_EN together in IDLE:
//   - the read and write complete in that cycle.
//   - the clear starts on the same edge and then zeroes every entry.
// - While BUSY: RD_EN and WR_EN are ignored, RD_VALID=0 and RD_DATA holds.
// - X/Z on any strobe is treated as 0.
// CONFIGURATION
// - REGFILE_ZERO_REG_EN defined:
//   - entry 0 is hard-wired zero; writes to address 0 are dropped.
//   - reads of address 0 return 0; no bypass applies to address 0.
// - REGFILE_ZERO_REG_EN undefined: entry 0 is an ordinary register.
// TESTING
// - Reset: assert RST=0 mid-run -> RD_DATA=0, RD_VALID=0, BUSY=0; reading all addresses returns 0.
// - Write/read: write 0xDEADBEEF to addr 7, then RD_EN with port0=7 and port1=3 next cycle
//   -> one cycle later port0=0xDEADBEEF, port1=0, RD_VALID=1 for one cycle.
// - Bypass: in the same cycle WR_EN addr 9 data 0x12345678 and RD_EN on both ports at addr 9
//   -> both ports = 0x12345678 next cycle.
// - Clear: fill all 32 entries with nonzero values, pulse CLR_REQ -> BUSY high for exactly 32 cycles;
//   WR_EN during BUSY is dropped; afterwards all entries read 0.
// - Reset mid-clear: pulse CLR_REQ, drop RST at cycle 10 -> BUSY=0 immediately; the FSM accepts
//   a write/read after RST=1.
// - Zero register: with REGFILE_ZERO_REG_EN, write 0xFFFFFFFF to addr 0 and read it -> 0.
//   Without the macro -> 0xFFFFFFFF.

Source files
------------

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-read-port register file with registered reads,
//   write-first bypass and a sequenced bulk-clear FSM, which lets the core
//   wipe the file without pulsing RST.
//
// Parameters
//   DW     data width in bits
//   DEPTH  number of registers (>= 2)
//   AW     address width, 2**AW >= DEPTH
//   NRD    number of read ports (1..4)
//
// Ports
//   CLK       clock, all state changes on posedge
//   RST       asynchronous active-low reset
//   RD_EN     read strobe shared by all read ports
//   RD_ADDR   packed read addresses, port k = [k*AW +: AW]
//   RD_DATA   packed registered read data, port k = [k*DW +: DW]
//   RD_VALID  one-cycle pulse, RD_DATA updated this cycle
//   WR_EN     write strobe
//   WR_ADDR   write address
//   WR_DATA   write data
//   CLR_REQ   start a bulk clear (pulse or level)
//   BUSY      high while the clear sequence runs
//
// Build option
//   REGFILE_ZERO_REG_EN  entry 0 is hard-wired zero; writes to it are
//                        dropped and it never takes part in bypass.
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RD_EN,
    input  logic [NRD*AW-1:0] RD_ADDR,
    output logic [NRD*DW-1:0] RD_DATA,
    output logic              RD_VALID,
    input  logic              WR_EN,
    input  logic [AW-1:0]     WR_ADDR,
    input  logic [DW-1:0]     WR_DATA,
    input  logic              CLR_REQ,
    output logic              BUSY
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     cnt_q;
    logic [DW-1:0]     mem [DEPTH];

    logic              rd_go;
    logic              wr_go;
    logic              clr_go;
    logic              idle;
    logic              wr_ok;
    logic              rd_fire;
    logic [AW-1:0]     rd_a;
    logic [NRD*DW-1:0] rd_next;

    // Addresses at or beyond DEPTH have no backing entry.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
        return a == '0;
`else
        return (a != a);
`endif
    endfunction

    // Strobes count as asserted only when they are a clean 1; X/Z reads as 0.
    always_comb begin
        rd_go  = (RD_EN === 1'b1);
        wr_go  = (WR_EN === 1'b1);
        clr_go = (CLR_REQ === 1'b1);
    end

    always_comb begin
        idle    = (state_q == IDLE);
        wr_ok   = idle && wr_go && in_range(WR_ADDR) && !is_zero_reg(WR_ADDR);
        rd_fire = idle && rd_go;
        BUSY    = (state_q == CLEAR);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_go) state_d = CLEAR;
            CLEAR:   if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter sits at 0 while idle, so it is already loaded on entry to CLEAR.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------- storage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[WR_ADDR] <= WR_DATA;
        end
    end

    // ---------------------------------------------------------- read path
    // Bypass keys off wr_ok, so dropped writes (out of range, zero reg)
    // never leak into read data.
    always_comb begin
        rd_next = '0;
        rd_a    = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_a = RD_ADDR[k*AW +: AW];
            if (in_range(rd_a) && !is_zero_reg(rd_a)) begin
                if (wr_ok && (WR_ADDR == rd_a)) begin
                    rd_next[k*DW +: DW] = WR_DATA;
                end else begin
                    rd_next[k*DW +: DW] = mem[rd_a];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= rd_fire;
            if (rd_fire) begin
                RD_DATA <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned SDEPTH = 24;
`ifdef REGFILE_ZERO_REG_EN
    localparam logic ZR = 1'b1;
`else
    localparam logic ZR = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              clr_req;
    logic              busy;
    logic [DW-1:0]     s_rd_data;
    logic              s_rd_valid;
    logic              s_busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_busy;
    int n_v;

    always #5 CLK = ~CLK;

    reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) u_dut (
        .CLK(CLK), .RST(RST),
        .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .CLR_REQ(clr_req), .BUSY(busy)
    );

    // Shallow single-port copy sharing the strobes: gives out-of-range addresses.
    reg_file_mp #(.DW(DW), .DEPTH(SDEPTH), .AW(AW), .NRD(1)) u_small (
        .CLK(CLK), .RST(RST),
        .RD_EN(rd_en), .RD_ADDR(rd_addr[AW-1:0]), .RD_DATA(s_rd_data), .RD_VALID(s_rd_valid),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .CLR_REQ(clr_req), .BUSY(s_busy)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [DW-1:0] fillv(input int unsigned i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0101 + 32'h1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_d0", rd_data[DW-1:0], 32'h0);
        check("rst_d1", rd_data[2*DW-1:DW], 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        RST = 1'b1;
        tick();

        // write then read, latency 1
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; set_rd(5'd7, 5'd3);
        tick();
        check("wr_rd_p0", rd_data[DW-1:0], 32'hDEAD_BEEF);
        check("wr_rd_p1", rd_data[2*DW-1:DW], 32'h0);
        check("wr_rd_valid", 32'(rd_valid), 32'h1);
        rd_en = 1'b0;
        tick();
        check("valid_pulse", 32'(rd_valid), 32'h0);
        check("rd_hold", rd_data[DW-1:0], 32'hDEAD_BEEF);

        // write-first bypass on both ports
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234_5678;
        rd_en = 1'b1; set_rd(5'd9, 5'd9);
        tick();
        wr_en = 1'b0;
        check("byp_p0", rd_data[DW-1:0], 32'h1234_5678);
        check("byp_p1", rd_data[2*DW-1:DW], 32'h1234_5678);
        set_rd(5'd9, 5'd7);
        tick();
        check("byp_stored", rd_data[DW-1:0], 32'h1234_5678);
        check("byp_other", rd_data[2*DW-1:DW], 32'hDEAD_BEEF);

        // X strobe counts as 0
        rd_en = 1'bx; set_rd(5'd3, 5'd3);
        tick();
        check("x_valid", 32'(rd_valid), 32'h0);
        check("x_hold", rd_data[DW-1:0], 32'h1234_5678);
        rd_en = 1'b0;

        // out-of-range on the 24-deep copy
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h55AA_55AA;
        rd_en = 1'b1; set_rd(5'd25, 5'd0);
        tick();
        wr_en = 1'b0;
        check("oor_byp", s_rd_data, 32'h0);
        check("oor_valid", 32'(s_rd_valid), 32'h1);
        check("inr_byp", rd_data[DW-1:0], 32'h55AA_55AA);
        tick();
        check("oor_rd", s_rd_data, 32'h0);
        check("oor_valid2", 32'(s_rd_valid), 32'h1);
        wr_en = 1'b1; wr_addr = 5'd23; wr_data = 32'h2323_2323; rd_en = 1'b0;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; set_rd(5'd23, 5'd0);
        tick();
        check("last_entry", s_rd_data, 32'h2323_2323);
        rd_en = 1'b0;

        // zero register
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; set_rd(5'd0, 5'd0);
        tick();
        check("zr_rd", rd_data[DW-1:0], ZR ? 32'h0 : 32'hFFFF_FFFF);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0F0F_0F0F; set_rd(5'd0, 5'd9);
        tick();
        check("zr_byp", rd_data[DW-1:0], ZR ? 32'h0 : 32'h0F0F_0F0F);
        check("zr_byp_p1", rd_data[2*DW-1:DW], 32'h1234_5678);
        wr_en = 1'b0; rd_en = 1'b0;

        // fill, then bulk clear with strobes active while busy
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = fillv(i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1; set_rd(5'd31, 5'd1);
        tick();
        check("fill_p0", rd_data[DW-1:0], fillv(31));
        check("fill_p1", rd_data[2*DW-1:DW], fillv(1));
        rd_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0BAD;
        rd_en = 1'b1; set_rd(5'd5, 5'd6);
        n_busy = 0; n_v = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            if (rd_valid) n_v++;
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("clr_busy_len", 32'(n_busy), 32'd32);
        check("clr_no_valid", 32'(n_v), 32'h0);
        check("clr_exit_valid", 32'(rd_valid), 32'h0);
        check("clr_hold_p0", rd_data[DW-1:0], fillv(31));
        check("clr_hold_p1", rd_data[2*DW-1:DW], fillv(1));
        for (int unsigned i = 0; i < 16; i++) begin
            rd_en = 1'b1; set_rd(AW'(i), AW'(i + 16));
            tick();
            check("clr_rd_lo", rd_data[DW-1:0], 32'h0);
            check("clr_rd_hi", rd_data[2*DW-1:DW], 32'h0);
        end
        rd_en = 1'b0;

        // clear, write and read together in IDLE
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
        rd_en = 1'b1; clr_req = 1'b1; set_rd(5'd3, 5'd9);
        tick();
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        check("cmb_p0", rd_data[DW-1:0], 32'h0000_0033);
        check("cmb_p1", rd_data[2*DW-1:DW], 32'h0);
        check("cmb_valid", 32'(rd_valid), 32'h1);
        check("cmb_busy", 32'(busy), 32'h1);
        n_busy = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            tick();
        end
        check("cmb_busy_len", 32'(n_busy), 32'd32);
        rd_en = 1'b1; set_rd(5'd3, 5'd3);
        tick();
        check("cmb_cleared", rd_data[DW-1:0], 32'h0);
        rd_en = 1'b0;

        // reset in the middle of a clear
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h3131_3131;
        tick();
        wr_en = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        check("mid_busy_pre", 32'(busy), 32'h1);
        RST = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_valid", 32'(rd_valid), 32'h0);
        check("mid_d0", rd_data[DW-1:0], 32'h0);
        tick();
        RST = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFE_F00D;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; set_rd(5'd12, 5'd31);
        tick();
        rd_en = 1'b0;
        check("post_p0", rd_data[DW-1:0], 32'hCAFE_F00D);
        check("post_p1", rd_data[2*DW-1:DW], 32'h0);
        check("post_valid", 32'(rd_valid), 32'h1);
        check("post_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
